// File: rtl/cam_frame_writer.sv
// Camera-side producer for the dual-port frame buffer: pairs OV7670 RGB565 bytes
// into pixels and writes them row-major into an IMG_W x IMG_H region of the RAM.
module cam_frame_writer #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int AW    = 17,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          capture_en,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite,
  output logic          frame_done,
  output logic          busy,
  output logic [7:0]    line_cnt
);

  localparam int XW = $clog2(IMG_W + 1);
  localparam logic [XW-1:0] W_LIM = XW'(IMG_W);
  localparam logic [7:0]    H_LIM = 8'(IMG_H);

  if (IMG_W * IMG_H > (1 << AW)) begin : gAddrCheck
    $error("cam_frame_writer: IMG_W*IMG_H does not fit in AW address bits");
  end
  if (DW != 16 || IMG_H > 255) begin : gShapeCheck
    $error("cam_frame_writer: DW must be 16 and IMG_H at most 255");
  end

  typedef enum logic [1:0] {WAIT_FRAME, CAPTURE, DONE} state_t;

  state_t          state_q, state_d;
  logic            vsync_q, href_q;
  logic            phase_q, phase_d;
  logic [7:0]      hi_q, hi_d;
  logic [XW-1:0]   x_q, x_d;
  logic [AW-1:0]   lineBase_q, lineBase_d;
  logic [7:0]      lineCnt_q, lineCnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic            wr_q, wr_d;

  logic frameStart, frameEnd, lineEnd;
  assign frameStart = vsync_q & ~vsync;
  assign frameEnd   = ~vsync_q & vsync;
  assign lineEnd    = href_q & ~href;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_FRAME;
      vsync_q    <= 1'b1;
      href_q     <= 1'b0;
      phase_q    <= 1'b0;
      hi_q       <= '0;
      x_q        <= '0;
      lineBase_q <= '0;
      lineCnt_q  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      vsync_q    <= vsync;
      href_q     <= href;
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      x_q        <= x_d;
      lineBase_q <= lineBase_d;
      lineCnt_q  <= lineCnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
    end
  end

  // A frame end takes priority over the byte on the bus, so a half-received
  // pixel or a pixel completing on that very edge is never written.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    hi_d       = hi_q;
    x_d        = x_q;
    lineBase_d = lineBase_q;
    lineCnt_d  = lineCnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_d       = 1'b0;
    case (state_q)
      WAIT_FRAME: begin
        if (frameStart && capture_en) begin
          state_d    = CAPTURE;
          phase_d    = 1'b0;
          x_d        = '0;
          lineBase_d = '0;
          lineCnt_d  = '0;
        end
      end
      CAPTURE: begin
        if (frameEnd) begin
          state_d = DONE;
          phase_d = 1'b0;
        end else if (href) begin
          if (!phase_q) begin
            hi_d    = px_data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (x_q < W_LIM && lineCnt_q < H_LIM) begin
              wr_d   = 1'b1;
              addr_d = lineBase_q + AW'(x_q);
              data_d = {hi_q, px_data};
              x_d    = x_q + XW'(1);
            end
          end
        end else if (lineEnd) begin
          phase_d = 1'b0;
          x_d     = '0;
          if (lineCnt_q < H_LIM) lineBase_d = lineBase_q + AW'(IMG_W);
          if (lineCnt_q != 8'hFF) lineCnt_d = lineCnt_q + 8'd1;
        end
      end
      DONE: state_d = WAIT_FRAME;
      default: state_d = WAIT_FRAME;
    endcase
  end

  assign addr_in    = addr_q;
  assign data_in    = data_q;
  assign regwrite   = wr_q;
  assign line_cnt   = lineCnt_q;
  assign busy       = (state_q == CAPTURE);
  assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_cam_frame_writer.sv
// Randomised bench for cam_frame_writer: frames are described as lists of line
// byte counts and the expected RAM writes are derived from row/column arithmetic.
module tb_cam_frame_writer;

  localparam int IMG_W = 160;
  localparam int IMG_H = 120;
  localparam int AW    = 17;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst_n, capture_en, vsync, href;
  logic [7:0]    px_data;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic          regwrite, frame_done, busy;
  logic [7:0]    line_cnt;

  cam_frame_writer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .capture_en(capture_en), .vsync(vsync), .href(href),
    .px_data(px_data), .addr_in(addr_in), .data_in(data_in), .regwrite(regwrite),
    .frame_done(frame_done), .busy(busy), .line_cnt(line_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chkEn = 1'b0;
  int fdCount = 0;
  int logAddr[$];
  int logData[$];
  bit [7:0] pat[$];
  int lineLens[$];

  // Expected outputs for the current cycle, and the values that become current after the next edge
  logic          expRw, expFd, expBusy;
  logic [7:0]    expLc;
  logic [AW-1:0] expAddr;
  logic [DW-1:0] expData;
  logic          nRw, nFd, nBusy;
  logic [7:0]    nLc;
  logic [AW-1:0] nAddr;
  logic [DW-1:0] nData;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkWrite(input string name, input int idx, input int a, input int d);
    if (idx >= logAddr.size()) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: only %0d writes seen, expected write #%0d", name, logAddr.size(), idx);
    end else begin
      checkOutput({name, "_addr"}, logAddr[idx], a);
      checkOutput({name, "_data"}, logData[idx], d);
    end
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("regwrite", regwrite, expRw);
      checkOutput("frame_done", frame_done, expFd);
      checkOutput("busy", busy, expBusy);
      checkOutput("line_cnt", line_cnt, expLc);
      checkOutput("addr_in", addr_in, expAddr);
      checkOutput("data_in", data_in, expData);
      if (regwrite === 1'b1) begin
        logAddr.push_back(int'(addr_in));
        logData.push_back(int'(data_in));
      end
      if (frame_done === 1'b1) fdCount++;
    end
  end

  task automatic applyStimulus(input bit vs, input bit hr, input bit [7:0] d, input bit ce);
    vsync = vs;
    href = hr;
    px_data = d;
    capture_en = ce;
    @(posedge clk);
    #1;
    expRw = nRw;
    expFd = nFd;
    expBusy = nBusy;
    expLc = nLc;
    expAddr = nAddr;
    expData = nData;
    nRw = 1'b0;
    nFd = 1'b0;
  endtask

  function automatic bit [7:0] nextByte();
    if (pat.size() > 0) return pat.pop_front();
    return 8'($urandom);
  endfunction

  task automatic resetModel();
    nRw = 0; nFd = 0; nBusy = 0; nLc = 0; nAddr = 0; nData = 0;
    expRw = 0; expFd = 0; expBusy = 0; expLc = 0; expAddr = 0; expData = 0;
  endtask

  task automatic clearLog();
    logAddr.delete();
    logData.delete();
    fdCount = 0;
  endtask

  // One frame: blanking, vsync fall, lines of lineLens[l] bytes, vsync rise.
  // With trunc set, vsync rises while the last byte of the last line is on the bus.
  task automatic run_frame(input bit cap, input bit trunc);
    bit [7:0] b, hi;
    int n;
    hi = 0;
    repeat (3) begin
      nBusy = 0;
      applyStimulus(1, 1'($urandom), 8'($urandom), 1'($urandom));
    end
    nBusy = cap;
    if (cap) nLc = 0;
    applyStimulus(0, 0, 8'($urandom), cap);
    for (int l = 0; l < lineLens.size(); l++) begin
      n = lineLens[l];
      repeat (2) applyStimulus(0, 0, 8'($urandom), 1'($urandom));
      for (int j = 0; j < n; j++) begin
        b = nextByte();
        if (trunc && l == lineLens.size() - 1 && j == n - 1) begin
          nBusy = 0;
          nFd = cap;
          applyStimulus(1, 1, b, 1'($urandom));
        end else begin
          if (j % 2 == 1 && cap && j / 2 < IMG_W && l < IMG_H) begin
            nRw = 1;
            nAddr = AW'(l * IMG_W + j / 2);
            nData = {hi, b};
          end
          if (j % 2 == 0) hi = b;
          applyStimulus(0, 1, b, 1'($urandom));
        end
      end
      if (!(trunc && l == lineLens.size() - 1)) begin
        if (cap) nLc = (l + 1 > 255) ? 8'd255 : 8'(l + 1);
        applyStimulus(0, 0, 8'($urandom), 1'($urandom));
      end
    end
    if (!trunc) begin
      nBusy = 0;
      nFd = cap;
      applyStimulus(1, 0, 8'($urandom), 1'($urandom));
    end
    applyStimulus(1, 0, 8'($urandom), 1'($urandom));
  endtask

  initial begin
    rst_n = 0; vsync = 1; href = 0; px_data = 0; capture_en = 0;
    resetModel();
    chkEn = 1;
    #1;
    checkOutput("reset_addr", addr_in, 0);
    checkOutput("reset_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;

    // Directed: two lines of three pixels
    clearLog();
    pat = '{8'hAA, 8'hAA, 8'h86, 8'h42, 8'hFF, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    lineLens = '{6, 6};
    run_frame(1, 0);
    checkOutput("d1_nwrites", logAddr.size(), 6);
    checkWrite("d1_w0", 0, 0, 'hAAAA);
    checkWrite("d1_w1", 1, 1, 'h8642);
    checkWrite("d1_w2", 2, 2, 'hFFFF);
    checkWrite("d1_w3", 3, 160, 'h1234);
    checkOutput("d1_line_cnt", line_cnt, 2);
    checkOutput("d1_fd_pulses", fdCount, 1);

    // Directed: 170-pixel line then a short one
    clearLog();
    lineLens = '{340, 4};
    run_frame(1, 0);
    checkOutput("d2_nwrites", logAddr.size(), 162);
    if (logAddr.size() > 160) begin
      checkOutput("d2_addr159", logAddr[159], 159);
      checkOutput("d2_addr160", logAddr[160], 160);
    end

    // Directed: odd byte count, next line pairs its own bytes
    clearLog();
    pat = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h97, 8'h53};
    lineLens = '{7, 2};
    run_frame(1, 0);
    checkOutput("d3_nwrites", logAddr.size(), 4);
    checkWrite("d3_w0", 0, 0, 'h0102);
    checkWrite("d3_w3", 3, 160, 'h9753);

    // Directed: capture disabled at frame start
    clearLog();
    lineLens = '{320, 320, 320};
    run_frame(0, 0);
    checkOutput("d4_nwrites", logAddr.size(), 0);
    checkOutput("d4_fd_pulses", fdCount, 0);

    // Directed: 125 full lines, only 120 stored
    clearLog();
    lineLens.delete();
    repeat (125) lineLens.push_back(320);
    run_frame(1, 0);
    checkOutput("d5_nwrites", logAddr.size(), IMG_W * IMG_H);
    if (logAddr.size() > 0) checkOutput("d5_last_addr", logAddr[logAddr.size() - 1], 19199);
    checkOutput("d5_line_cnt", line_cnt, 125);

    // Directed: reset pulse right after a hi byte
    clearLog();
    repeat (2) applyStimulus(1, 0, 8'h00, 1);
    nBusy = 1;
    nLc = 0;
    applyStimulus(0, 0, 8'h00, 1);
    applyStimulus(0, 1, 8'h5A, 1);
    #2;
    rst_n = 0;
    vsync = 1;
    href = 0;
    resetModel();
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_regwrite", regwrite, 0);
    checkOutput("rst_addr", addr_in, 0);
    checkOutput("rst_line_cnt", line_cnt, 0);
    repeat (2) applyStimulus(1, 0, 8'h00, 1);
    rst_n = 1;
    lineLens = '{4};
    pat = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(1, 0);
    checkOutput("d6_nwrites", logAddr.size(), 2);
    checkWrite("d6_w0", 0, 0, 'h1122);
    checkOutput("d6_fd_pulses", fdCount, 1);

    // Randomised frames, some truncated by an early vsync
    for (int f = 0; f < 12; f++) begin
      bit cap, trunc;
      cap = ($urandom_range(0, 3) != 0);
      trunc = $urandom_range(0, 2) == 0;
      lineLens.delete();
      repeat ($urandom_range(1, 4)) lineLens.push_back($urandom_range(1, 30));
      run_frame(cap, trunc);
    end

    chkEn = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
